// File: rtl/intr_ctrl_core.sv
// Eight-line fixed-priority interrupt controller core: edge capture, mask,
// in-service nesting and a request/acknowledge/EOI handshake to the CPU.
module intr_ctrl_core #(
  parameter logic [7:0] VECTOR_BASE  = 8'h20,
  parameter logic [7:0] SPURIOUS_VEC = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  output logic       int_req,
  input  logic       int_ack,
  input  logic       eoi,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output logic       spurious,
  output logic [7:0] irr,
  output logic [7:0] imr,
  output logic [7:0] isr
);

  // state     | meaning
  // S_IDLE    | no request presented to the CPU
  // S_REQ     | int_req asserted, waiting for int_ack
  // S_ACK_LAT | one-cycle gap after an acknowledge
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK_LAT} state_t;

  state_t     state_q, state_d;
  logic [7:0] irq_q, irr_q, irr_d, imr_q, imr_d, isr_q, isr_d;
  logic [7:0] vector_q, vector_d;
  logic       vvalid_q, spur_q, spur_d;
  logic       armed_q;

  logic [7:0] edge_w, allowed, eligible, win_oh, eoi_clr;
  logic [2:0] winner, isr_top;
  logic       take_ack, spur_ack;

  always_comb begin
    // A line already high when reset is released is a level, not an edge.
    edge_w   = armed_q ? (irq_in & ~irq_q) : 8'h00;
    allowed  = 8'h00;
    winner   = 3'd0;
    isr_top  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      allowed[i] = ((isr_q >> i) == 8'h00);
    end
    eligible = irr_q & ~imr_q & allowed;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) winner = 3'(i);
      if (isr_q[i])    isr_top = 3'(i);
    end
    win_oh   = 8'h01 << winner;
    eoi_clr  = (eoi && (isr_q != 8'h00)) ? (8'h01 << isr_top) : 8'h00;
    take_ack = int_ack && (state_q == S_REQ) && (eligible != 8'h00);
    spur_ack = int_ack && !take_ack;
    // A new edge wins over the acknowledge clearing the same bit.
    irr_d    = (irr_q & ~(take_ack ? win_oh : 8'h00)) | edge_w;
    isr_d    = (isr_q & ~eoi_clr) | (take_ack ? win_oh : 8'h00);
    imr_d    = mask_we ? mask_wdata : imr_q;
    spur_d   = spur_ack;
    if (take_ack)      vector_d = VECTOR_BASE + {5'b00000, winner};
    else if (spur_ack) vector_d = SPURIOUS_VEC;
    else               vector_d = vector_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (eligible != 8'h00) state_d = S_REQ;
      S_REQ: begin
        if (int_ack)                 state_d = S_ACK_LAT;
        else if (eligible == 8'h00)  state_d = S_IDLE;
      end
      S_ACK_LAT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      irq_q    <= 8'h00;
      irr_q    <= 8'h00;
      imr_q    <= 8'hFF;
      isr_q    <= 8'h00;
      vector_q <= 8'h00;
      vvalid_q <= 1'b0;
      spur_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_in;
      irr_q    <= irr_d;
      imr_q    <= imr_d;
      isr_q    <= isr_d;
      vector_q <= vector_d;
      vvalid_q <= int_ack;
      spur_q   <= spur_d;
      armed_q  <= 1'b1;
    end
  end

  assign int_req      = (state_q == S_REQ);
  assign vector_out   = vector_q;
  assign vector_valid = vvalid_q;
  assign spurious     = spur_q;
  assign irr          = irr_q;
  assign imr          = imr_q;
  assign isr          = isr_q;

endmodule

// File: tb/tb_intr_ctrl_core.sv
// Directed bench for intr_ctrl_core: linear handshake scenarios with
// hand-computed expected register and vector values.
module tb_intr_ctrl_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       int_req;
  logic       int_ack;
  logic       eoi;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic       spurious;
  logic [7:0] irr, imr, isr;

  int n_chk  = 0;
  int n_fail = 0;

  intr_ctrl_core dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .int_req(int_req), .int_ack(int_ack),
    .eoi(eoi), .vector_out(vector_out), .vector_valid(vector_valid),
    .spurious(spurious), .irr(irr), .imr(imr), .isr(isr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = 8'h01; mask_we = 1'b0; mask_wdata = 8'h00;
    int_ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    chk("rst_int_req", {7'd0, int_req}, 8'h00);
    chk("rst_vector", vector_out, 8'h00);
    chk("rst_vvalid", {7'd0, vector_valid}, 8'h00);
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_imr", imr, 8'hFF);

    // held level at reset release, then unmask
    rst = 1'b0; tick(); tick();
    mask_we = 1'b1; mask_wdata = 8'h00; tick();
    mask_we = 1'b0;
    chk("unmask_imr", imr, 8'h00);
    tick(); tick();
    chk("held_level_irr", irr, 8'h00);
    chk("held_level_req", {7'd0, int_req}, 8'h00);

    // edge on bit 3
    irq_in = 8'h09; tick();
    chk("b3_irr", irr, 8'h08);
    chk("b3_req_early", {7'd0, int_req}, 8'h00);
    tick();
    chk("b3_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("b3_vector", vector_out, 8'h23);
    chk("b3_vvalid", {7'd0, vector_valid}, 8'h01);
    chk("b3_spur", {7'd0, spurious}, 8'h00);
    chk("b3_isr", isr, 8'h08);
    chk("b3_irr_clr", irr, 8'h00);
    chk("b3_req_low", {7'd0, int_req}, 8'h00);
    tick();
    chk("b3_vvalid_pulse", {7'd0, vector_valid}, 8'h00);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    chk("b3_eoi_isr", isr, 8'h00);
    irq_in = 8'h00; tick();

    // bits 2 and 6 together
    irq_in = 8'h44; tick();
    chk("b26_irr", irr, 8'h44);
    tick();
    chk("b26_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("b26_vec1", vector_out, 8'h26);
    chk("b26_isr1", isr, 8'h40);
    chk("b26_irr1", irr, 8'h04);
    tick(); tick();
    chk("b2_blocked", {7'd0, int_req}, 8'h00);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    chk("b26_eoi", isr, 8'h00);
    tick();
    chk("b2_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("b26_vec2", vector_out, 8'h22);
    chk("b26_isr2", isr, 8'h04);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    irq_in = 8'h00; tick();

    // nesting under ISR[4]
    irq_in = 8'h10; tick(); tick();
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("nest_isr4", isr, 8'h10);
    irq_in = 8'h50; tick(); tick();
    chk("nest_req6", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("nest_vec6", vector_out, 8'h26);
    chk("nest_isr50", isr, 8'h50);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    chk("nest_eoi", isr, 8'h10);
    irq_in = 8'h52; tick();
    chk("nest_irr1", irr, 8'h02);
    tick(); tick();
    chk("nest_b1_blocked", {7'd0, int_req}, 8'h00);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    tick();
    chk("nest_b1_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("nest_vec1", vector_out, 8'h21);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    irq_in = 8'h00; tick();

    // mask during REQ
    irq_in = 8'h20; tick(); tick();
    chk("mask_req", {7'd0, int_req}, 8'h01);
    mask_we = 1'b1; mask_wdata = 8'h20; tick();
    mask_we = 1'b0;
    tick();
    chk("mask_req_drop", {7'd0, int_req}, 8'h00);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("mask_vec", vector_out, 8'hFF);
    chk("mask_spur", {7'd0, spurious}, 8'h01);
    chk("mask_vvalid", {7'd0, vector_valid}, 8'h01);
    chk("mask_irr", irr, 8'h20);
    chk("mask_isr", isr, 8'h00);
    mask_we = 1'b1; mask_wdata = 8'h00; tick();
    mask_we = 1'b0;
    chk("mask_spur_pulse", {7'd0, spurious}, 8'h00);
    tick();
    chk("unmask_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("unmask_vec", vector_out, 8'h25);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    irq_in = 8'h00; tick();

    // new edge on bit 4 in its own ack cycle
    irq_in = 8'h10; tick(); tick();
    irq_in = 8'h00; tick();
    chk("sim4_req", {7'd0, int_req}, 8'h01);
    irq_in = 8'h10; int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("sim4_irr", irr, 8'h10);
    chk("sim4_isr", isr, 8'h10);
    chk("sim4_vec", vector_out, 8'h24);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    tick();
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("sim4_vec2", vector_out, 8'h24);
    chk("sim4_irr2", irr, 8'h00);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    irq_in = 8'h00; tick();

    // eoi with ack: EOI retires bit 3, ack takes bit 6
    irq_in = 8'h08; tick(); tick();
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    irq_in = 8'h48; tick(); tick();
    chk("eoiack_req", {7'd0, int_req}, 8'h01);
    int_ack = 1'b1; eoi = 1'b1; tick();
    int_ack = 1'b0; eoi = 1'b0;
    chk("eoiack_isr", isr, 8'h40);
    chk("eoiack_vec", vector_out, 8'h26);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    irq_in = 8'h00; tick();

    // eoi with ack while ISR=80, bit 3 pending: winner sees pre-EOI ISR
    irq_in = 8'h80; tick(); tick();
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    irq_in = 8'h88; tick(); tick();
    chk("isr80_blocked", {7'd0, int_req}, 8'h00);
    int_ack = 1'b1; eoi = 1'b1; tick();
    int_ack = 1'b0; eoi = 1'b0;
    chk("isr80_spur", {7'd0, spurious}, 8'h01);
    chk("isr80_vec", vector_out, 8'hFF);
    chk("isr80_isr", isr, 8'h00);
    chk("isr80_irr", irr, 8'h08);
    tick();
    chk("isr80_req", {7'd0, int_req}, 8'h01);

    // async reset while in REQ
    rst = 1'b1; #1;
    chk("arst_req", {7'd0, int_req}, 8'h00);
    chk("arst_irr", irr, 8'h00);
    chk("arst_isr", isr, 8'h00);
    chk("arst_imr", imr, 8'hFF);
    #2 rst = 1'b0; irq_in = 8'h00; tick();
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("post_rst_spur", {7'd0, spurious}, 8'h01);
    chk("post_rst_vec", vector_out, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
